// File: rtl/mem_bus_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_bus_pkg
// Description : Shared constants for the two-master memory arbiter slice:
//               default bus widths, ROM select bit position and master ids.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_bus_pkg;

    // Default address and data widths.
    localparam int c_def_aw = 8;
    localparam int c_def_dw = 8;

    // Address bit that selects ROM (1) or RAM (0) at the default width.
    // The top module recomputes this as AW-1 for its own AW.
    localparam int c_rom_sel_bit = c_def_aw - 1;

    // Master identifiers; also the encoding of the round-robin pointer.
    localparam logic c_m0 = 1'b0;
    localparam logic c_m1 = 1'b1;

endpackage
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// ============================================================================
// Module      : rr_arb2
// Description : Two-way round-robin arbiter. Grants are combinational from
//               the requests and a registered "last granted" pointer; the
//               pointer moves only on a cycle that actually grants.
// Ports       : clk     - clock
//               rst     - synchronous active-high reset (forces grants low,
//                         pointer to master 1 so master 0 wins first)
//               i_req0  - master 0 request
//               i_req1  - master 1 request
//               o_gnt0  - master 0 granted this cycle
//               o_gnt1  - master 1 granted this cycle
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arb2
    import mem_bus_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic i_req0,
    input  logic i_req1,
    output logic o_gnt0,
    output logic o_gnt1
);

    logic r_last;
    logic w_last_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last <= c_m1;
        end else begin
            r_last <= w_last_nxt;
        end
    end

    always_comb begin
        o_gnt0     = 1'b0;
        o_gnt1     = 1'b0;
        w_last_nxt = r_last;
        if (!rst) begin
            if (i_req0 && i_req1) begin
                // Contention: favour whichever master did not win last.
                if (r_last == c_m1) begin
                    o_gnt0 = 1'b1;
                end else begin
                    o_gnt1 = 1'b1;
                end
            end else begin
                o_gnt0 = i_req0;
                o_gnt1 = i_req1;
            end
            if (o_gnt0) begin
                w_last_nxt = c_m0;
            end else if (o_gnt1) begin
                w_last_nxt = c_m1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Shares one single-cycle memory port between a CPU (master 0)
//               and a DMA/loader (master 1). One transaction per cycle,
//               round-robin on contention. The upper address bit maps ROM;
//               writes there are dropped and flagged on rom_wr_err.
// Ports       : clk, reset            - clock, synchronous active-high reset
//               mN_req/we/addr/wdata  - master N request side
//               mN_gnt                - master N granted this cycle (comb.)
//               mN_rdata/mN_rvalid    - registered read data, 1-cycle pulse
//               mem_addr/we/wdata     - shared memory port
//               mem_rdata             - memory read data (comb. from addr)
//               rom_wr_err            - pulse after a suppressed ROM write
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter
    import mem_bus_pkg::*;
#(
    parameter int AW = c_def_aw,
    parameter int DW = c_def_dw
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          m0_req,
    input  logic          m0_we,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    output logic          m0_gnt,
    output logic [DW-1:0] m0_rdata,
    output logic          m0_rvalid,
    input  logic          m1_req,
    input  logic          m1_we,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    output logic          m1_gnt,
    output logic [DW-1:0] m1_rdata,
    output logic          m1_rvalid,
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          rom_wr_err
);

    localparam int c_rom_bit = AW - 1;

    logic          w_gnt0;
    logic          w_gnt1;
    logic          w_we_sel;
    logic          w_rom_hit;
    logic [DW-1:0] r_m0_rdata;
    logic [DW-1:0] r_m1_rdata;
    logic          r_m0_rvalid;
    logic          r_m1_rvalid;
    logic          r_rom_wr_err;

    rr_arb2 u_arb (
        .clk    (clk),
        .rst    (reset),
        .i_req0 (m0_req),
        .i_req1 (m1_req),
        .o_gnt0 (w_gnt0),
        .o_gnt1 (w_gnt1)
    );

    // Address/data default to master 0 so the bus is quiet when idle.
    always_comb begin
        mem_addr  = m0_addr;
        mem_wdata = m0_wdata;
        w_we_sel  = 1'b0;
        if (w_gnt1) begin
            mem_addr  = m1_addr;
            mem_wdata = m1_wdata;
            w_we_sel  = m1_we;
        end else if (w_gnt0) begin
            w_we_sel  = m0_we;
        end
        w_rom_hit = mem_addr[c_rom_bit];
        mem_we    = w_we_sel & ~w_rom_hit;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_m0_rdata   <= '0;
            r_m1_rdata   <= '0;
            r_m0_rvalid  <= 1'b0;
            r_m1_rvalid  <= 1'b0;
            r_rom_wr_err <= 1'b0;
        end else begin
            r_m0_rvalid  <= w_gnt0 & ~m0_we;
            r_m1_rvalid  <= w_gnt1 & ~m1_we;
            r_rom_wr_err <= w_we_sel & w_rom_hit;
            if (w_gnt0 && !m0_we) begin
                r_m0_rdata <= mem_rdata;
            end
            if (w_gnt1 && !m1_we) begin
                r_m1_rdata <= mem_rdata;
            end
        end
    end

    assign m0_gnt     = w_gnt0;
    assign m1_gnt     = w_gnt1;
    assign m0_rdata   = r_m0_rdata;
    assign m1_rdata   = r_m1_rdata;
    // A read returning into a reset cycle is discarded, not delivered.
    assign m0_rvalid  = r_m0_rvalid & ~reset;
    assign m1_rvalid  = r_m1_rvalid & ~reset;
    assign rom_wr_err = r_rom_wr_err;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Self-checking bench for mem_arbiter: directed scenarios plus
//               randomized traffic against a transaction-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic       m0_req, m0_we, m1_req, m1_we;
    logic [7:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic       m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
    logic [7:0] m0_rdata, m1_rdata;
    logic [7:0] mem_addr, mem_wdata, mem_rdata;
    logic       mem_we, rom_wr_err;

    int checks = 0;
    int errors = 0;

    // Reference model: who won most recently, and per-master read results.
    int         mdl_last = 1;
    logic [7:0] mdl_rdata [2];
    bit         mdl_rvalid [2];
    bit         mdl_err;

    mem_arbiter #(.AW(8), .DW(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .m0_req     (m0_req),
        .m0_we      (m0_we),
        .m0_addr    (m0_addr),
        .m0_wdata   (m0_wdata),
        .m0_gnt     (m0_gnt),
        .m0_rdata   (m0_rdata),
        .m0_rvalid  (m0_rvalid),
        .m1_req     (m1_req),
        .m1_we      (m1_we),
        .m1_addr    (m1_addr),
        .m1_wdata   (m1_wdata),
        .m1_gnt     (m1_gnt),
        .m1_rdata   (m1_rdata),
        .m1_rvalid  (m1_rvalid),
        .mem_addr   (mem_addr),
        .mem_we     (mem_we),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .rom_wr_err (rom_wr_err)
    );

    always #5 clk = ~clk;

    // Which master the rules say is served now: -1 none, 0, or 1.
    function automatic int pick();
        if (reset) return -1;
        if (m0_req && m1_req) return (mdl_last == 0) ? 1 : 0;
        if (m0_req) return 0;
        if (m1_req) return 1;
        return -1;
    endfunction

    // Advance one clock and apply the transaction rules to the model.
    task automatic tick();
        int         g;
        bit         we;
        logic [7:0] a;
        g  = pick();
        we = (g == 1) ? m1_we : m0_we;
        a  = (g == 1) ? m1_addr : m0_addr;
        @(posedge clk);
        mdl_rvalid[0] = 0;
        mdl_rvalid[1] = 0;
        mdl_err       = 0;
        if (reset) begin
            mdl_rdata[0] = 8'h00;
            mdl_rdata[1] = 8'h00;
            mdl_last     = 1;
        end else if (g >= 0) begin
            mdl_last = g;
            if (we) begin
                mdl_err = (a >= 8'h80);
            end else begin
                mdl_rdata[g]  = mem_rdata;
                mdl_rvalid[g] = 1;
            end
        end
        #1;
    endtask

    task automatic idle_inputs();
        m0_req = 0; m0_we = 0; m0_addr = 8'h00; m0_wdata = 8'h00;
        m1_req = 0; m1_we = 0; m1_addr = 8'h00; m1_wdata = 8'h00;
        mem_rdata = 8'h00;
    endtask

    task automatic test_reset();
        reset = 1;
        m0_req = 1; m0_we = 1; m0_addr = 8'h01;
        m1_req = 1; m1_we = 1; m1_addr = 8'h02;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if (m0_gnt !== 1'b0 || m1_gnt !== 1'b0) begin
                errors++;
                $display("FAIL reset_gnt: got m0=%b m1=%b want 0 0", m0_gnt, m1_gnt);
            end
            checks++;
            if (mem_we !== 1'b0) begin
                errors++;
                $display("FAIL reset_we: got %b want 0", mem_we);
            end
            tick();
        end
        reset = 0;
        idle_inputs();
        @(negedge clk);
        checks++;
        if (m0_rdata !== 8'h00 || m1_rdata !== 8'h00 || m0_rvalid !== 1'b0 ||
            m1_rvalid !== 1'b0 || rom_wr_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: got rd0=%h rd1=%h rv0=%b rv1=%b err=%b want 00 00 0 0 0",
                     m0_rdata, m1_rdata, m0_rvalid, m1_rvalid, rom_wr_err);
        end
        tick();
    endtask

    task automatic test_m0_read();
        m0_req = 1; m0_we = 0; m0_addr = 8'h85; mem_rdata = 8'h3C;
        @(negedge clk);
        checks++;
        if (m0_gnt !== 1'b1 || m1_gnt !== 1'b0 || mem_we !== 1'b0 || mem_addr !== 8'h85) begin
            errors++;
            $display("FAIL m0_read_grant: got gnt0=%b gnt1=%b we=%b addr=%h want 1 0 0 85",
                     m0_gnt, m1_gnt, mem_we, mem_addr);
        end
        tick();
        idle_inputs();
        @(negedge clk);
        checks++;
        if (m0_rvalid !== 1'b1 || m0_rdata !== 8'h3C || m1_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL m0_read_data: got rv0=%b rd0=%h rv1=%b want 1 3c 0",
                     m0_rvalid, m0_rdata, m1_rvalid);
        end
        tick();
        checks++;
        if (m0_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL m0_read_pulse: got rv0=%b want 0", m0_rvalid);
        end
    endtask

    task automatic test_contention();
        logic [7:0] data [4];
        reset = 1; idle_inputs();
        tick();
        reset = 0;
        m0_req = 1; m0_we = 0; m0_addr = 8'h11;
        m1_req = 1; m1_we = 0; m1_addr = 8'h22;
        for (int i = 0; i < 4; i++) begin
            data[i] = 8'h40 + 8'(i);
            mem_rdata = data[i];
            @(negedge clk);
            checks++;
            if (m0_gnt !== ((i % 2) == 0) || m1_gnt !== ((i % 2) == 1)) begin
                errors++;
                $display("FAIL contention_gnt[%0d]: got m0=%b m1=%b want %b %b",
                         i, m0_gnt, m1_gnt, (i % 2) == 0, (i % 2) == 1);
            end
            if (i > 0) begin
                checks++;
                if (((i % 2) == 1 && (m0_rvalid !== 1'b1 || m0_rdata !== data[i-1] || m1_rvalid !== 1'b0)) ||
                    ((i % 2) == 0 && (m1_rvalid !== 1'b1 || m1_rdata !== data[i-1] || m0_rvalid !== 1'b0))) begin
                    errors++;
                    $display("FAIL contention_rvalid[%0d]: got rv0=%b rd0=%h rv1=%b rd1=%h want prev data %h",
                             i, m0_rvalid, m0_rdata, m1_rvalid, m1_rdata, data[i-1]);
                end
            end
            tick();
        end
        idle_inputs();
    endtask

    task automatic test_m1_write();
        m1_req = 1; m1_we = 1; m1_addr = 8'h10; m1_wdata = 8'hA5;
        @(negedge clk);
        checks++;
        if (m1_gnt !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 8'h10 || mem_wdata !== 8'hA5) begin
            errors++;
            $display("FAIL m1_write_bus: got gnt1=%b we=%b addr=%h wd=%h want 1 1 10 a5",
                     m1_gnt, mem_we, mem_addr, mem_wdata);
        end
        tick();
        idle_inputs();
        @(negedge clk);
        checks++;
        if (m1_rvalid !== 1'b0 || rom_wr_err !== 1'b0) begin
            errors++;
            $display("FAIL m1_write_after: got rv1=%b err=%b want 0 0", m1_rvalid, rom_wr_err);
        end
        tick();
    endtask

    task automatic test_rom_write();
        m0_req = 1; m0_we = 1; m0_addr = 8'h90; m0_wdata = 8'h55;
        @(negedge clk);
        checks++;
        if (m0_gnt !== 1'b1 || mem_we !== 1'b0 || rom_wr_err !== 1'b0) begin
            errors++;
            $display("FAIL rom_write_bus: got gnt0=%b we=%b err=%b want 1 0 0",
                     m0_gnt, mem_we, rom_wr_err);
        end
        tick();
        idle_inputs();
        @(negedge clk);
        checks++;
        if (rom_wr_err !== 1'b1 || m0_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL rom_write_err: got err=%b rv0=%b want 1 0", rom_wr_err, m0_rvalid);
        end
        tick();
        checks++;
        if (rom_wr_err !== 1'b0) begin
            errors++;
            $display("FAIL rom_write_pulse: got err=%b want 0", rom_wr_err);
        end
    endtask

    // Last grant was m0 (ROM write); idling must not move the pointer.
    task automatic test_idle();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (m0_gnt !== 1'b0 || m1_gnt !== 1'b0 || mem_we !== 1'b0 ||
                m0_rvalid !== 1'b0 || m1_rvalid !== 1'b0) begin
                errors++;
                $display("FAIL idle[%0d]: got gnt=%b%b we=%b rv=%b%b want 00 0 00",
                         i, m0_gnt, m1_gnt, mem_we, m0_rvalid, m1_rvalid);
            end
            tick();
        end
        m0_req = 1; m1_req = 1;
        @(negedge clk);
        checks++;
        if (m0_gnt !== 1'b0 || m1_gnt !== 1'b1) begin
            errors++;
            $display("FAIL idle_pointer: got m0=%b m1=%b want 0 1", m0_gnt, m1_gnt);
        end
        tick();
        idle_inputs();
        tick();
    endtask

    task automatic test_reset_after_read();
        m0_req = 1; m0_we = 0; m0_addr = 8'h33; mem_rdata = 8'hE7;
        tick();
        reset = 1; m0_req = 1; m1_req = 1;
        @(negedge clk);
        checks++;
        if (m0_rvalid !== 1'b0 || m0_gnt !== 1'b0 || m1_gnt !== 1'b0) begin
            errors++;
            $display("FAIL rst_read_drop: got rv0=%b gnt=%b%b want 0 00", m0_rvalid, m0_gnt, m1_gnt);
        end
        tick();
        reset = 0;
        @(negedge clk);
        checks++;
        if (m0_rdata !== 8'h00 || m0_rvalid !== 1'b0 || m0_gnt !== 1'b1 || m1_gnt !== 1'b0) begin
            errors++;
            $display("FAIL rst_read_after: got rd0=%h rv0=%b gnt=%b%b want 00 0 10",
                     m0_rdata, m0_rvalid, m0_gnt, m1_gnt);
        end
        tick();
        idle_inputs();
        tick();
    endtask

    task automatic test_random();
        int         g;
        logic [7:0] ea, ed;
        bit         ewe;
        for (int i = 0; i < 400; i++) begin
            reset    = ($urandom_range(0, 39) == 0);
            m0_req   = 1'($urandom);
            m1_req   = 1'($urandom);
            m0_we    = 1'($urandom);
            m1_we    = 1'($urandom);
            m0_addr  = 8'($urandom);
            m1_addr  = 8'($urandom);
            m0_wdata = 8'($urandom);
            m1_wdata = 8'($urandom);
            mem_rdata = 8'($urandom);
            @(negedge clk);
            g   = pick();
            ea  = (g == 1) ? m1_addr : m0_addr;
            ed  = (g == 1) ? m1_wdata : m0_wdata;
            ewe = (g >= 0) && ((g == 1) ? m1_we : m0_we) && (ea < 8'h80);
            checks++;
            if (m0_gnt !== (g == 0) || m1_gnt !== (g == 1)) begin
                errors++;
                $display("FAIL rand_gnt[%0d]: got %b%b want %b%b", i, m0_gnt, m1_gnt, g == 0, g == 1);
            end
            checks++;
            if (mem_addr !== ea || mem_wdata !== ed || mem_we !== ewe) begin
                errors++;
                $display("FAIL rand_bus[%0d]: got a=%h d=%h we=%b want %h %h %b",
                         i, mem_addr, mem_wdata, mem_we, ea, ed, ewe);
            end
            checks++;
            if (m0_rvalid !== (mdl_rvalid[0] && !reset) || m1_rvalid !== (mdl_rvalid[1] && !reset) ||
                m0_rdata !== mdl_rdata[0] || m1_rdata !== mdl_rdata[1] || rom_wr_err !== mdl_err) begin
                errors++;
                $display("FAIL rand_resp[%0d]: got rv=%b%b rd=%h/%h err=%b want %b%b %h/%h %b",
                         i, m0_rvalid, m1_rvalid, m0_rdata, m1_rdata, rom_wr_err,
                         mdl_rvalid[0] && !reset, mdl_rvalid[1] && !reset,
                         mdl_rdata[0], mdl_rdata[1], mdl_err);
            end
            tick();
        end
        reset = 0;
        idle_inputs();
    endtask

    initial begin
        mdl_rdata[0] = 8'h00; mdl_rdata[1] = 8'h00;
        mdl_rvalid[0] = 0;    mdl_rvalid[1] = 0;
        mdl_err = 0;
        reset = 1;
        idle_inputs();
        #1;
        test_reset();
        test_m0_read();
        test_contention();
        test_m1_write();
        test_rom_write();
        test_idle();
        test_reset_after_read();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
